// File: rtl/seg_decode_rx.sv
// Seven-segment receiver: debounces a 9-bit segment pattern, decodes legal hex
// glyphs to a digit and keeps sticky/saturating error status for illegal glyphs.
module seg_decode_rx #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] seg_in,
  input  logic       clear,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       new_digit,
  output logic       code_err,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;

  localparam logic [7:0] STABLE_W = 8'(STABLE_CYCLES);

  state_t     state;
  logic [8:0] s_q;
  logic [7:0] cnt;
  logic [7:0] cnt_inc;
  logic       accept;
  logic       dec_legal;
  logic [3:0] dec_val;

  // Decode the held sample: on an acceptance edge seg_in equals s_q, so the
  // decoder never sees the raw input.
  always_comb begin
    dec_legal = 1'b1;
    dec_val   = 4'h0;
    case (s_q)
      9'h03F: dec_val = 4'h0;
      9'h006: dec_val = 4'h1;
      9'h05B: dec_val = 4'h2;
      9'h04F: dec_val = 4'h3;
      9'h066: dec_val = 4'h4;
      9'h06D: dec_val = 4'h5;
      9'h07D: dec_val = 4'h6;
      9'h007: dec_val = 4'h7;
      9'h07F: dec_val = 4'h8;
      9'h06F: dec_val = 4'h9;
      9'h077: dec_val = 4'hA;
      9'h07C: dec_val = 4'hB;
      9'h039: dec_val = 4'hC;
      9'h05E: dec_val = 4'hD;
      9'h079: dec_val = 4'hE;
      9'h071: dec_val = 4'hF;
      default: dec_legal = 1'b0;
    endcase
  end

  assign cnt_inc = cnt + 8'd1;
  assign accept  = (state == SETTLE) && (seg_in == s_q) && (cnt_inc == STABLE_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      s_q         <= '0;
      cnt         <= '0;
      digit       <= '0;
      digit_valid <= 1'b0;
      new_digit   <= 1'b0;
      code_err    <= 1'b0;
      err_count   <= '0;
    end else begin
      new_digit <= 1'b0;

      // Any change restarts the settle window, whatever the current state.
      if (seg_in != s_q) begin
        s_q   <= seg_in;
        cnt   <= 8'd1;
        state <= SETTLE;
      end else if (state == SETTLE) begin
        cnt <= cnt_inc;
        if (cnt_inc == STABLE_W) state <= LOCKED;
      end

      if (accept) begin
        if (s_q == 9'h000) begin
          digit_valid <= 1'b0;
        end else if (dec_legal) begin
          digit       <= dec_val;
          digit_valid <= 1'b1;
          code_err    <= 1'b0;
          new_digit   <= !digit_valid || (dec_val != digit);
        end else begin
          digit_valid <= 1'b0;
          code_err    <= 1'b1;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
      end

      // Clear wins over an illegal acceptance on the same edge.
      if (clear) begin
        err_count <= '0;
        code_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_decode_rx.sv
// Bench for seg_decode_rx: directed scenarios plus random glyph bursts, all
// checked each cycle against a run-length reference model.
module tb_seg_decode_rx;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] seg_in;
  logic       clear;
  logic [3:0] digit;
  logic       digit_valid;
  logic       new_digit;
  logic       code_err;
  logic [7:0] err_count;

  int total = 0;
  int bad   = 0;

  seg_decode_rx #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .clear(clear),
    .digit(digit), .digit_valid(digit_valid), .new_digit(new_digit),
    .code_err(code_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Glyph table indexed by hex value.
  logic [8:0] glyph [16] = '{9'h03F, 9'h006, 9'h05B, 9'h04F, 9'h066, 9'h06D, 9'h07D, 9'h007,
                             9'h07F, 9'h06F, 9'h077, 9'h07C, 9'h039, 9'h05E, 9'h079, 9'h071};

  // Reference model: a pattern is taken exactly when it has been seen for S
  // consecutive samples; the post-reset idle value counts as long-standing.
  logic [8:0] m_last;
  int         m_run;
  int         m_digit;
  int         m_valid;
  int         m_nd;
  int         m_err;
  int         m_cnt;

  task automatic model_edge(input logic [8:0] s, input logic c, input logic r);
    int idx;
    if (r) begin
      m_last = 9'h000; m_run = 1000;
      m_digit = 0; m_valid = 0; m_nd = 0; m_err = 0; m_cnt = 0;
    end else begin
      m_nd = 0;
      if (s == m_last) begin
        if (m_run < 1000) m_run++;
      end else begin
        m_last = s;
        m_run  = 1;
      end
      if (m_run == S) begin
        idx = -1;
        for (int k = 0; k < 16; k++) if (glyph[k] == s) idx = k;
        if (s == 9'h000) begin
          m_valid = 0;
        end else if (idx >= 0) begin
          m_nd    = (m_valid == 0 || m_digit != idx) ? 1 : 0;
          m_digit = idx;
          m_valid = 1;
          m_err   = 0;
        end else begin
          m_valid = 0;
          m_err   = 1;
          if (m_cnt < 255) m_cnt++;
        end
      end
      if (c) begin
        m_cnt = 0;
        m_err = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("digit",       32'(digit),       32'(m_digit));
    chk("digit_valid", 32'(digit_valid), 32'(m_valid));
    chk("new_digit",   32'(new_digit),   32'(m_nd));
    chk("code_err",    32'(code_err),    32'(m_err));
    chk("err_count",   32'(err_count),   32'(m_cnt));
  endtask

  task automatic step(input logic [8:0] s, input logic c, input logic r);
    seg_in = s;
    clear  = c;
    rst    = r;
    @(posedge clk);
    model_edge(s, c, r);
    #1;
    check_all();
  endtask

  task automatic hold(input logic [8:0] s, input int n);
    for (int k = 0; k < n; k++) step(s, 1'b0, 1'b0);
  endtask

  initial begin
    seg_in = '0; clear = 1'b0; rst = 1'b1;

    // Reset, then idle on blank.
    step(9'h000, 1'b0, 1'b1);
    step(9'h000, 1'b0, 1'b1);
    hold(9'h000, 5);
    chk("idle_valid", 32'(digit_valid), 32'd0);
    $display("txn reset/idle: digit=%0h valid=%0b", digit, digit_valid);

    // Stable legal pattern, then long hold with no re-acceptance.
    hold(9'h05B, 3);
    chk("stable_early", 32'(digit_valid), 32'd0);
    hold(9'h05B, 1);
    chk("stable_digit", 32'(digit), 32'd2);
    chk("stable_pulse", 32'(new_digit), 32'd1);
    hold(9'h05B, 6);
    $display("txn stable 05B: digit=%0h valid=%0b", digit, digit_valid);

    // Glitch rejection.
    hold(9'h07F, 2);
    hold(9'h006, 1);
    hold(9'h07F, 3);
    chk("glitch_hold", 32'(digit), 32'd2);
    hold(9'h07F, 1);
    chk("glitch_digit", 32'(digit), 32'd8);
    chk("glitch_pulse", 32'(new_digit), 32'd1);
    $display("txn glitch: digit=%0h", digit);

    // Illegal then recovery.
    hold(9'h0FF, 4);
    chk("illegal_err", 32'(code_err), 32'd1);
    chk("illegal_cnt", 32'(err_count), 32'd1);
    hold(9'h07D, 4);
    chk("recover_digit", 32'(digit), 32'd6);
    chk("recover_err", 32'(code_err), 32'd0);
    $display("txn illegal/recover: digit=%0h err_count=%0d", digit, err_count);

    // Same digit revisited through blank.
    hold(9'h04F, 4);
    hold(9'h000, 4);
    chk("blank_valid", 32'(digit_valid), 32'd0);
    hold(9'h04F, 4);
    chk("revisit_pulse", 32'(new_digit), 32'd1);
    chk("revisit_digit", 32'(digit), 32'd3);
    $display("txn revisit: digit=%0h", digit);

    // Saturation, then clear on an illegal acceptance edge.
    for (int i = 0; i < 260; i++) hold((i % 2) ? 9'h180 : 9'h100, 4);
    chk("sat_cnt", 32'(err_count), 32'd255);
    hold(9'h100, 3);
    step(9'h100, 1'b1, 1'b0);
    chk("clear_cnt", 32'(err_count), 32'd0);
    chk("clear_err", 32'(code_err), 32'd0);
    $display("txn saturate/clear: err_count=%0d", err_count);

    // Reset mid-settle.
    hold(9'h077, 2);
    step(9'h077, 1'b0, 1'b1);
    chk("rst_digit", 32'(digit), 32'd0);
    hold(9'h077, 3);
    chk("rst_early", 32'(digit_valid), 32'd0);
    hold(9'h077, 1);
    chk("rst_accept", 32'(digit), 32'hA);
    $display("txn reset mid-settle: digit=%0h", digit);

    // Random bursts of legal, blank and illegal patterns.
    for (int b = 0; b < 400; b++) begin
      logic [8:0] v;
      int n;
      int kind;
      kind = int'($urandom_range(0, 9));
      if (kind < 6)      v = glyph[$urandom_range(0, 15)];
      else if (kind < 7) v = 9'h000;
      else               v = 9'($urandom_range(1, 511));
      n = int'($urandom_range(1, 7));
      for (int k = 0; k < n; k++)
        step(v, ($urandom_range(0, 15) == 0), ($urandom_range(0, 299) == 0));
    end
    $display("txn random: done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
